// File: rtl/tff_bank_sequencer.sv
// Start/stop up/down counter built from a bank of T flip-flops. The sequencer
// computes the per-bit toggle vector each cycle, and the bank applies it.

module tff_bank #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q ^ t_vec;
    if (load_en) q_d = load_val;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

module tff_bank_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             reload,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_e;

  state_e state_q, state_d;
  logic   done_q, done_d;

  logic [WIDTH-1:0] up_tog, dn_tog;
  logic             run_active, limit_eq, hit, count_en, load_en;

  assign run_active = (state_q == RUN) && !stop && !rst;
  assign limit_eq   = (q == limit);
  // The cycle after a reload hit (done_q high) does not re-detect the limit,
  // and q parks there, so load_val==limit yields done every second cycle.
  assign hit        = run_active && limit_eq && !done_q;
  assign count_en   = run_active && !limit_eq;
  assign load_en    = !rst && ((((state_q == IDLE) || (state_q == HOLD)) && load) ||
                               (hit && reload));

  always_comb begin
    up_tog    = '0;
    dn_tog    = '0;
    up_tog[0] = 1'b1;
    dn_tog[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      up_tog[i] = up_tog[i-1] & q[i-1];
      dn_tog[i] = dn_tog[i-1] & ~q[i-1];
    end
  end

  assign t_vec = count_en ? (up_dn ? up_tog : dn_tog) : '0;

  tff_bank #(.WIDTH(WIDTH)) u_bank (
    .clk      (clk),
    .rst      (rst),
    .load_en  (load_en),
    .load_val (load_val),
    .t_vec    (t_vec),
    .q        (q)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start && !stop) state_d = RUN;
      RUN: begin
        if (stop) begin
          state_d = HOLD;
        end else if (hit) begin
          done_d = 1'b1;
          if (!reload) state_d = DONE;
        end
      end
      HOLD: if (start && !stop) state_d = RUN;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN) || (state_q == HOLD);
  assign done = done_q;

endmodule

// File: tb/tb_tff_bank_sequencer.sv
// Bench for tff_bank_sequencer: directed scenarios with literal expectations,
// then randomized stimulus checked every cycle against a behavioural model.

module tb_tff_bank_sequencer;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;
  localparam int M_DONE = 3;

  logic         clk = 1'b0;
  logic         rst, start, stop, up_dn, load, reload;
  logic [W-1:0] load_val, limit;
  logic [W-1:0] q, t_vec;
  logic         busy, done;

  always #5 clk = ~clk;

  tff_bank_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .reload   (reload),
    .q        (q),
    .t_vec    (t_vec),
    .busy     (busy),
    .done     (done)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode, counter value as an integer, done flag.
  int m_mode  = M_IDLE;
  int m_q     = 0;
  bit m_done  = 1'b0;
  bit m_valid = 1'b0;
  bit m_prev_done;

  always @(posedge clk) begin
    if (rst) begin
      m_mode  = M_IDLE;
      m_q     = 0;
      m_done  = 1'b0;
      m_valid = 1'b1;
    end else begin
      m_prev_done = m_done;
      m_done      = 1'b0;
      case (m_mode)
        M_IDLE: begin
          if (load) m_q = int'(load_val);
          if (start && !stop) m_mode = M_RUN;
        end
        M_RUN: begin
          if (stop) m_mode = M_HOLD;
          else if (m_q == int'(limit)) begin
            if (!m_prev_done) begin
              m_done = 1'b1;
              if (reload) m_q = int'(load_val);
              else        m_mode = M_DONE;
            end
          end else begin
            m_q = up_dn ? (m_q + 1) % MOD : (m_q + MOD - 1) % MOD;
          end
        end
        M_HOLD: begin
          if (load) m_q = int'(load_val);
          if (start && !stop) m_mode = M_RUN;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  function automatic logic [W-1:0] exp_tvec();
    logic [W-1:0] a, b;
    int nq;
    if (rst || m_mode != M_RUN || stop || m_q == int'(limit)) return '0;
    nq = up_dn ? (m_q + 1) % MOD : (m_q + MOD - 1) % MOD;
    a  = m_q[W-1:0];
    b  = nq[W-1:0];
    return a ^ b;
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_q",    32'(q),     32'(m_q));
      chk("model_tvec", 32'(t_vec), 32'(exp_tvec()));
      chk("model_busy", 32'(busy),  32'(m_mode == M_RUN || m_mode == M_HOLD));
      chk("model_done", 32'(done),  32'(m_done));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; up_dn = 1'b1; load = 1'b0;
    reload = 1'b0; load_val = '0; limit = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_q", 32'(q), 0); chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0); chk("rst_tvec", 32'(t_vec), 0);

    // load in IDLE
    load_val = 4'd3; load = 1'b1; step(); load = 1'b0;
    chk("load_q", 32'(q), 3); chk("load_busy", 32'(busy), 0); chk("load_tvec", 32'(t_vec), 0);

    // one-shot up count 3..7
    limit = 4'd7; up_dn = 1'b1; reload = 1'b0; start = 1'b1; step(); start = 1'b0;
    chk("run_q3", 32'(q), 3); chk("run_busy", 32'(busy), 1); chk("run_tvec3", 32'(t_vec), 32'h7);
    step(); chk("run_q4", 32'(q), 4);
    step(); step(); step();
    chk("hit_q7", 32'(q), 7); chk("hit_tvec", 32'(t_vec), 0); chk("hit_done", 32'(done), 0);
    step(); chk("done_pulse", 32'(done), 1); chk("done_q", 32'(q), 7); chk("done_busy", 32'(busy), 0);
    step(); chk("idle_done", 32'(done), 0); chk("idle_q", 32'(q), 7);

    // wrap 14,15,0,1,2
    load_val = 4'd14; load = 1'b1; step(); load = 1'b0;
    limit = 4'd2; start = 1'b1; step(); start = 1'b0;
    chk("wrap_q14", 32'(q), 14);
    step(); chk("wrap_q15", 32'(q), 15); chk("wrap_tvec", 32'(t_vec), 32'hF);
    step(); chk("wrap_q0", 32'(q), 0);
    step(); step(); chk("wrap_q2", 32'(q), 2);
    step(); chk("wrap_done", 32'(done), 1);
    step();

    // down auto-reload 9..5
    load_val = 4'd9; load = 1'b1; step(); load = 1'b0;
    up_dn = 1'b0; limit = 4'd5; reload = 1'b1; start = 1'b1; step(); start = 1'b0;
    chk("rl_q9", 32'(q), 9);
    step(); chk("rl_q8", 32'(q), 8);
    step(); step(); step(); chk("rl_q5", 32'(q), 5); chk("rl_done0", 32'(done), 0);
    step(); chk("rl_reload_q", 32'(q), 9); chk("rl_done1", 32'(done), 1); chk("rl_busy", 32'(busy), 1);
    step(); step(); step(); chk("rl_q6", 32'(q), 6);

    // stop at 6 for 3 cycles with load
    stop = 1'b1; load = 1'b1; load_val = 4'd1;
    step(); chk("stop_q6", 32'(q), 6); chk("stop_busy", 32'(busy), 1);
    step(); step();
    stop = 1'b0; load = 1'b0;
    chk("hold_q1", 32'(q), 1); chk("hold_tvec", 32'(t_vec), 0);
    start = 1'b1; step(); start = 1'b0;
    chk("resume_q1", 32'(q), 1);
    step(); chk("resume_q0", 32'(q), 0);
    repeat (6) step();
    chk("pre_rst_q10", 32'(q), 10);

    // reset mid-RUN wins over start
    rst = 1'b1; start = 1'b1; step(); rst = 1'b0; start = 1'b0;
    chk("mid_rst_q", 32'(q), 0); chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0); chk("mid_rst_tvec", 32'(t_vec), 0);

    // load_val == limit with reload: done every second cycle
    load_val = 4'd5; limit = 4'd5; reload = 1'b1; load = 1'b1; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    chk("eq_d0", 32'(done), 0);
    step(); chk("eq_d1", 32'(done), 1); chk("eq_q", 32'(q), 5);
    step(); chk("eq_d2", 32'(done), 0);
    step(); chk("eq_d3", 32'(done), 1);
    rst = 1'b1; step(); rst = 1'b0;

    // randomized phase, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom_range(0, 63) == 0);
      start    = ($urandom_range(0, 3) == 0);
      stop     = ($urandom_range(0, 9) == 0);
      up_dn    = $urandom_range(0, 1) != 0;
      load     = ($urandom_range(0, 3) == 0);
      reload   = $urandom_range(0, 1) != 0;
      load_val = 4'($urandom_range(0, MOD - 1));
      limit    = ($urandom_range(0, 7) == 0) ? load_val : 4'($urandom_range(0, MOD - 1));
      step();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
